// File: rtl/axis_m_out_if.sv
// AXI4-Stream master output stage of the FFT core.
// Reads every result word from output memory, splits it into two beats,
// buffers the beats in a small FIFO and streams them out with TLAST.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   start_i                   pulse: results ready in output memory
//   busy_o, done_o            transfer in progress / finished pulse
//   mem_rd_en_o/addr_o/data_i output memory read port (1-cycle latency)
//   m_axis_*                  AXI4-Stream master (tdata/tvalid/tready/tlast)
module axis_m_out_if #(
    parameter int VLW_WDT           = 64,
    parameter int M_TDATA_WDT       = 32,
    parameter int M_FIFO_SIZE       = 16,
    parameter int C_FFT_SIZE_LOG2   = 12,
    parameter int OUTPUT_MEM_OFFSET = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       mem_rd_en_o,
    output logic [C_FFT_SIZE_LOG2-1:0] mem_rd_addr_o,
    input  logic [VLW_WDT-1:0]         mem_rd_data_i,
    output logic [M_TDATA_WDT-1:0]     m_axis_tdata_o,
    output logic                       m_axis_tvalid_o,
    input  logic                       m_axis_tready_i,
    output logic                       m_axis_tlast_o
);

    localparam int AW = $clog2(M_FIFO_SIZE);
    localparam int CW = AW + 1;
    localparam int BW = C_FFT_SIZE_LOG2 + 1;

    localparam logic [C_FFT_SIZE_LOG2-1:0] OFFS =
        C_FFT_SIZE_LOG2'(OUTPUT_MEM_OFFSET);
    localparam logic [C_FFT_SIZE_LOG2-1:0] LAST_WORD = '1;
    localparam logic [BW-1:0]              LAST_BEAT = '1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t                     state;
    logic [C_FFT_SIZE_LOG2-1:0] word_idx;
    logic [BW-1:0]              beat_cnt;
    logic                       inflight;
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    logic [CW-1:0]              fifo_count;
    logic [M_TDATA_WDT-1:0]     fifo_mem [M_FIFO_SIZE];

    logic rd_ok;
    logic pop;
    logic last_head;

    // Reserve room for the word already in flight plus the one issued now,
    // so the two-beat write can never overflow the FIFO.
    assign rd_ok = (state == READ) &&
                   ((32'(fifo_count) + (inflight ? 32'd2 : 32'd0) + 32'd2)
                    <= 32'(M_FIFO_SIZE));

    assign m_axis_tvalid_o = (fifo_count != '0);
    assign pop             = m_axis_tvalid_o && m_axis_tready_i;
    assign last_head       = (beat_cnt == LAST_BEAT);
    assign m_axis_tlast_o  = m_axis_tvalid_o && last_head;
    assign m_axis_tdata_o  = m_axis_tvalid_o ? fifo_mem[rd_ptr] : '0;

    assign mem_rd_en_o   = rd_ok;
    assign mem_rd_addr_o = rd_ok ? (OFFS + word_idx) : '0;
    assign busy_o        = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            word_idx <= '0;
            beat_cnt <= '0;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (pop)
                beat_cnt <= beat_cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state    <= READ;
                        word_idx <= '0;
                        beat_cnt <= '0;
                    end
                end
                READ: begin
                    if (rd_ok) begin
                        word_idx <= word_idx + 1'b1;
                        if (word_idx == LAST_WORD)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && last_head) begin
                        state  <= IDLE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // inflight marks the cycle in which read data is valid on mem_rd_data_i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            inflight <= rd_ok;
            if (inflight)
                wr_ptr <= wr_ptr + AW'(2);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count
                        + (inflight ? CW'(2) : CW'(0))
                        - (pop ? CW'(1) : CW'(0));
        end
    end

    // wr_ptr is always even, so the two halves never collide.
    always_ff @(posedge clk) begin
        if (inflight) begin
            fifo_mem[wr_ptr]         <= mem_rd_data_i[M_TDATA_WDT-1:0];
            fifo_mem[wr_ptr + AW'(1)] <= mem_rd_data_i[VLW_WDT-1:M_TDATA_WDT];
        end
    end

    fifo_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        inflight |-> ((32'(fifo_count) + 32'd2 - (pop ? 32'd1 : 32'd0))
                      <= 32'(M_FIFO_SIZE))
    );

endmodule

// File: tb/tb_axis_m_out_if.sv
// Randomized bench for axis_m_out_if: three instances (default size,
// 8-word, 8-word with address offset 6) checked against a beat-order model.
module tb_axis_m_out_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start;
    logic        tready;
    wire  [2:0]  busy, done, rd_en, tvalid, tlast;
    wire  [11:0] addr_a;
    wire  [2:0]  addr_b, addr_c;
    wire  [31:0] td_a, td_b, td_c;
    logic [63:0] rd_a, rd_b, rd_c;

    logic [31:0] tdata_v [3];
    logic [11:0] addr_v [3];

    int total = 0;
    int bad   = 0;

    int tot_t [3] = '{8192, 16, 16};
    int dep_t [3] = '{4096, 8, 8};
    int off_t [3] = '{0, 0, 6};

    int   nbeat [3];
    int   nrd [3];
    int   ndone [3];
    logic stall [3];
    logic [31:0] pdata [3];
    logic plast [3];

    always #5 clk = ~clk;

    axis_m_out_if u_a (
        .clk(clk), .rst(rst), .start_i(start[0]),
        .busy_o(busy[0]), .done_o(done[0]),
        .mem_rd_en_o(rd_en[0]), .mem_rd_addr_o(addr_a),
        .mem_rd_data_i(rd_a),
        .m_axis_tdata_o(td_a), .m_axis_tvalid_o(tvalid[0]),
        .m_axis_tready_i(tready), .m_axis_tlast_o(tlast[0])
    );

    axis_m_out_if #(.C_FFT_SIZE_LOG2(3)) u_b (
        .clk(clk), .rst(rst), .start_i(start[1]),
        .busy_o(busy[1]), .done_o(done[1]),
        .mem_rd_en_o(rd_en[1]), .mem_rd_addr_o(addr_b),
        .mem_rd_data_i(rd_b),
        .m_axis_tdata_o(td_b), .m_axis_tvalid_o(tvalid[1]),
        .m_axis_tready_i(tready), .m_axis_tlast_o(tlast[1])
    );

    axis_m_out_if #(.C_FFT_SIZE_LOG2(3), .OUTPUT_MEM_OFFSET(6)) u_c (
        .clk(clk), .rst(rst), .start_i(start[2]),
        .busy_o(busy[2]), .done_o(done[2]),
        .mem_rd_en_o(rd_en[2]), .mem_rd_addr_o(addr_c),
        .mem_rd_data_i(rd_c),
        .m_axis_tdata_o(td_c), .m_axis_tvalid_o(tvalid[2]),
        .m_axis_tready_i(tready), .m_axis_tlast_o(tlast[2])
    );

    always_comb begin
        tdata_v[0] = td_a;
        tdata_v[1] = td_b;
        tdata_v[2] = td_c;
        addr_v[0]  = addr_a;
        addr_v[1]  = {9'b0, addr_b};
        addr_v[2]  = {9'b0, addr_c};
    end

    function automatic logic [63:0] mk_word(input int a);
        return {32'(2 * a + 1), 32'(2 * a)};
    endfunction

    function automatic int exp_addr(input int i, input int n);
        return (off_t[i] + n) % dep_t[i];
    endfunction

    function automatic int exp_beat(input int i, input int k);
        return 2 * exp_addr(i, k / 2) + (k % 2);
    endfunction

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output memory: word at address a holds beats 2a (low) and 2a+1 (high).
    always @(posedge clk) begin
        if (rd_en[0]) rd_a <= mk_word(int'(addr_a));
        if (rd_en[1]) rd_b <= mk_word(int'(addr_b));
        if (rd_en[2]) rd_c <= mk_word(int'(addr_c));
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                nbeat[i] = 0;
                nrd[i]   = 0;
                ndone[i] = 0;
                stall[i] = 1'b0;
            end else begin
                if (rd_en[i]) begin
                    chk("rd_addr", addr_v[i], exp_addr(i, nrd[i]));
                    nrd[i]++;
                    chk("fifo_bound", (2 * nrd[i] - nbeat[i]) <= 16, 1);
                end
                if (tvalid[i]) begin
                    if (stall[i]) begin
                        chk("hold_data", tdata_v[i], pdata[i]);
                        chk("hold_last", tlast[i], plast[i]);
                    end
                    chk("beat_data", tdata_v[i], exp_beat(i, nbeat[i]));
                    chk("beat_last", tlast[i], nbeat[i] == tot_t[i] - 1);
                    if (tready)
                        nbeat[i]++;
                end
                stall[i] = tvalid[i] && !tready;
                pdata[i] = tdata_v[i];
                plast[i] = tlast[i];
                if (done[i]) begin
                    ndone[i]++;
                    chk("done_beats", nbeat[i], tot_t[i]);
                    chk("done_busy", busy[i], 0);
                end
            end
        end
    end

    task automatic start_pulse(input int i);
        @(posedge clk);
        #1 start[i] = 1'b1;
        @(posedge clk);
        #1 start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int n0, input int budget,
                             output int n);
        n = n0;
        while (!done[i] && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done[i])
            chk("timeout", 0, 1);
    endtask

    int n;

    initial begin
        rst    = 1'b1;
        start  = '0;
        tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rden", rd_en, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata_v[0], 0);
        rst = 1'b0;

        // Full default-size transfer, tready always high.
        tready = 1'b1;
        start_pulse(0);
        chk("lat_rden", rd_en[0], 1);
        chk("lat_busy", busy[0], 1);
        chk("lat_tv1", tvalid[0], 0);
        @(posedge clk);
        #1 chk("lat_tv2", tvalid[0], 0);
        @(posedge clk);
        #1 chk("lat_tv3", tvalid[0], 1);
        chk("lat_first", tdata_v[0], 0);
        wait_done(0, 2, 20000, n);
        chk("full_cycles", n, 8194);
        @(posedge clk);
        #1 chk("full_ndone", ndone[0], 1);
        chk("full_busy", busy[0], 0);

        // 8-word transfer, ~30% tready, start re-pulsed mid-transfer.
        start_pulse(1);
        n = 0;
        while (!done[1] && n < 2000) begin
            @(posedge clk);
            #1;
            tready   = ($urandom_range(0, 99) < 30);
            start[1] = (n == 5 || n == 20);
            n++;
        end
        start[1] = 1'b0;
        if (!done[1])
            chk("timeout", 0, 1);
        repeat (20) @(posedge clk);
        #1 chk("rand_ndone", ndone[1], 1);
        chk("rand_beats", nbeat[1], 16);
        chk("rand_busy", busy[1], 0);

        // Default size, tready held low for 100 cycles.
        tready = 1'b0;
        nbeat[0] = 0;
        nrd[0]   = 0;
        ndone[0] = 0;
        start_pulse(0);
        repeat (100) @(posedge clk);
        #1 chk("hold_reads", nrd[0], 8);
        chk("hold_rden", rd_en[0], 0);
        chk("hold_beats", nbeat[0], 0);
        tready = 1'b1;
        wait_done(0, 0, 20000, n);
        @(posedge clk);
        #1 chk("hold_ndone", ndone[0], 1);

        // Offset 6 with random tready.
        start_pulse(2);
        n = 0;
        while (!done[2] && n < 2000) begin
            @(posedge clk);
            #1 tready = ($urandom_range(0, 99) < 50);
            n++;
        end
        if (!done[2])
            chk("timeout", 0, 1);
        @(posedge clk);
        #1 chk("off_ndone", ndone[2], 1);
        chk("off_reads", nrd[2], 8);

        // Reset mid-transfer, then a fresh transfer.
        tready = 1'b1;
        nbeat[1] = 0;
        nrd[1]   = 0;
        ndone[1] = 0;
        start_pulse(1);
        n = 0;
        while (nbeat[1] < 6 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pre_rst_beats", nbeat[1], 6);
        chk("pre_rst_tv", tvalid[1], 1);
        #2 rst = 1'b1;
        #1 chk("arst_tvalid", tvalid[1], 0);
        chk("arst_busy", busy[1], 0);
        chk("arst_rden", rd_en[1], 0);
        chk("arst_tlast", tlast[1], 0);
        chk("arst_tdata", tdata_v[1], 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("arst_done", ndone[1], 0);
        start_pulse(1);
        wait_done(1, 0, 2000, n);
        @(posedge clk);
        #1 chk("rst_re_ndone", ndone[1], 1);
        chk("rst_re_beats", nbeat[1], 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
